// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared constants, baud table and FSM state type for uart_rx_ctrl
//
// Purpose: register map, CTRL/STATUS bit positions, CTRL reset value, the
// 16-entry clocks-per-bit table (100 MHz system clock) and the engine FSM states.
package uart_rx_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int CTRL_EIGHT = 4;
  localparam int CTRL_PEN   = 5;
  localparam int CTRL_OHEL  = 6;
  localparam int CTRL_EN    = 7;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_PERR   = 2;
  localparam int ST_FERR   = 3;
  localparam int ST_UOVF   = 4;
  localparam int ST_FOVF   = 5;

  localparam logic [7:0] CTRL_RESET = 8'h14;

  typedef enum logic [1:0] {
    RST_ENG  = 2'd0,
    IDLE     = 2'd1,
    ACK      = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  // 300 .. 921600 baud; selectors 12..15 saturate at the fastest rate
  localparam logic [18:0] BAUD_TABLE [16] = '{
    19'd333333, 19'd83333, 19'd41667, 19'd20833,
    19'd10417,  19'd5208,  19'd2604,  19'd1736,
    19'd868,    19'd434,   19'd217,   19'd109,
    19'd109,    19'd109,   19'd109,   19'd109
  };

  function automatic logic [18:0] baud_count(input logic [3:0] sel);
    return BAUD_TABLE[sel];
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - processor-side register port of uart_rx_ctrl
//
// Signals: i_cs access strobe, i_we write/read select, i_addr register index,
// i_wdata write data, o_rdata registered read data (valid the cycle after i_cs).
// master: processor side; slave: uart_rx_ctrl.
interface uart_rx_ctrl_if;
  logic       i_cs;
  logic       i_we;
  logic [1:0] i_addr;
  logic [7:0] i_wdata;
  logic [7:0] o_rdata;

  modport master (output i_cs, output i_we, output i_addr, output i_wdata, input o_rdata);
  modport slave  (input i_cs, input i_we, input i_addr, input i_wdata, output o_rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO for received UART frames
//
// Ports: i_clk, i_rst_n (async active-low), i_push/i_din write side,
// i_pop read side with o_dout showing the head entry, o_full, o_empty,
// o_count occupancy (clog2(DEPTH)+1 bits). DEPTH must be a power of 2, >= 2.
// A push on a full FIFO is accepted only together with a pop.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_count = count;
  assign o_dout  = mem[rd_ptr];
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_din;
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - configures, sequences and services a UART_RX engine
//
// Ports: i_clk, i_rst_n (async active-low); bus (uart_rx_ctrl_if.slave) with
// registers 0 CTRL, 1 STATUS (W1C [5:2]), 2 DATA (read pops FIFO), 3 COUNT;
// engine side i_rxrdy/i_perr/i_ferr/i_ovf/i_rx_dout in, o_read ack pulse,
// o_rx_rst, o_eight, o_pen, o_ohel, o_rate out.
// Optional UART_RX_CTRL_IRQ_EN: adds o_irq and makes address 3 writable as
// IRQ_MASK ([0] not empty, [1] full, [2] any error flag).
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  uart_rx_ctrl_if.slave        bus,
  input  logic                 i_rxrdy,
  input  logic                 i_perr,
  input  logic                 i_ferr,
  input  logic                 i_ovf,
  input  logic [7:0]           i_rx_dout,
  output logic                 o_read,
  output logic                 o_rx_rst,
  output logic                 o_eight,
  output logic                 o_pen,
  output logic                 o_ohel,
  output logic [18:0]          o_rate
`ifdef UART_RX_CTRL_IRQ_EN
  ,
  output logic                 o_irq
`endif
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int RCW = $clog2(RST_CYCLES + 1);

  state_t          state_q, state_d;
  logic [7:0]      ctrl_q;
  logic [RCW-1:0]  rst_cnt;
  logic [3:0]      err_q;        // {fifo ovf, uart ovf, ferr, perr}
  logic [3:0]      err_set, err_clr;
  logic [7:0]      rdata_q, status;
  logic            ctrl_wr, sts_wr, data_rd, en, rst_done, capture;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;

  assign ctrl_wr  = bus.i_cs &  bus.i_we & (bus.i_addr == ADDR_CTRL);
  assign sts_wr   = bus.i_cs &  bus.i_we & (bus.i_addr == ADDR_STATUS);
  assign data_rd  = bus.i_cs & ~bus.i_we & (bus.i_addr == ADDR_DATA);
  assign en       = ctrl_q[CTRL_EN];
  assign rst_done = (rst_cnt == RCW'(RST_CYCLES - 1));
  // A CTRL write in the capture cycle wins: the engine is being reset anyway
  assign capture  = (state_q == IDLE) & i_rxrdy & ~ctrl_wr;
  assign fifo_pop = data_rd & ~fifo_empty;
  assign status   = {2'b00, err_q, fifo_full, ~fifo_empty};
  assign bus.o_rdata = rdata_q;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (capture),
    .i_din   (i_rx_dout),
    .i_pop   (fifo_pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RST_ENG;
      rst_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != RST_ENG || ctrl_wr) rst_cnt <= '0;
      else if (!rst_done)                rst_cnt <= rst_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    o_rx_rst = 1'b0;
    o_read   = 1'b0;
    case (state_q)
      RST_ENG: begin
        o_rx_rst = 1'b1;
        if (rst_done && en) state_d = IDLE;
      end
      IDLE:     if (i_rxrdy) state_d = ACK;
      ACK: begin
        o_read  = ~ctrl_wr;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: if (!i_rxrdy) state_d = IDLE;
      default:  state_d = RST_ENG;
    endcase
    if (ctrl_wr || !en) state_d = RST_ENG;
  end

  // Format outputs follow the write data directly so they change one cycle after the write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q  <= CTRL_RESET;
      o_rate  <= baud_count(CTRL_RESET[3:0]);
      o_eight <= CTRL_RESET[CTRL_EIGHT];
      o_pen   <= CTRL_RESET[CTRL_PEN];
      o_ohel  <= CTRL_RESET[CTRL_OHEL];
    end else if (ctrl_wr) begin
      ctrl_q  <= bus.i_wdata;
      o_rate  <= baud_count(bus.i_wdata[3:0]);
      o_eight <= bus.i_wdata[CTRL_EIGHT];
      o_pen   <= bus.i_wdata[CTRL_PEN];
      o_ohel  <= bus.i_wdata[CTRL_OHEL];
    end
  end

  // Sticky flags: a new error in the clearing cycle survives the clear
  assign err_set = {capture & fifo_full & ~fifo_pop, capture & i_ovf, capture & i_ferr, capture & i_perr};
  assign err_clr = sts_wr ? bus.i_wdata[ST_FOVF:ST_PERR] : 4'b0000;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      err_q <= (err_q & ~err_clr) | err_set;
      if (bus.i_cs && !bus.i_we) begin
        case (bus.i_addr)
          ADDR_CTRL:   rdata_q <= ctrl_q;
          ADDR_STATUS: rdata_q <= status;
          ADDR_DATA:   rdata_q <= fifo_empty ? 8'h00 : fifo_dout;
          default:     rdata_q <= 8'(fifo_count);
        endcase
      end
    end
  end

`ifdef UART_RX_CTRL_IRQ_EN
  logic [2:0] irq_mask;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_mask <= '0;
      o_irq    <= 1'b0;
    end else begin
      if (bus.i_cs && bus.i_we && bus.i_addr == ADDR_COUNT) irq_mask <= bus.i_wdata[2:0];
      o_irq <= |(irq_mask & {|err_q, fifo_full, ~fifo_empty});
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;
  localparam logic [1:0] A_CTRL = 2'd0, A_STATUS = 2'd1, A_DATA = 2'd2, A_COUNT = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxrdy = 1'b0, perr = 1'b0, ferr = 1'b0, ovf = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic o_read, o_rx_rst, o_eight, o_pen, o_ohel;
  logic [18:0] o_rate;
`ifdef UART_RX_CTRL_IRQ_EN
  logic o_irq;
`endif

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .RST_CYCLES(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .i_rxrdy   (rxrdy),
    .i_perr    (perr),
    .i_ferr    (ferr),
    .i_ovf     (ovf),
    .i_rx_dout (rx_dout),
    .o_read    (o_read),
    .o_rx_rst  (o_rx_rst),
    .o_eight   (o_eight),
    .o_pen     (o_pen),
    .o_ohel    (o_ohel),
    .o_rate    (o_rate)
`ifdef UART_RX_CTRL_IRQ_EN
    ,
    .o_irq     (o_irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO as a queue plus four sticky flags
  logic [7:0] mq[$];
  bit m_perr = 0, m_ferr = 0, m_uovf = 0, m_fovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_rate(input logic [3:0] sel);
    int baud;
    case (sel)
      4'd0: baud = 300;     4'd1: baud = 1200;    4'd2: baud = 2400;    4'd3: baud = 4800;
      4'd4: baud = 9600;    4'd5: baud = 19200;   4'd6: baud = 38400;   4'd7: baud = 57600;
      4'd8: baud = 115200;  4'd9: baud = 230400;  4'd10: baud = 460800;
      default: baud = 921600;
    endcase
    return (100_000_000 + baud / 2) / baud;
  endfunction

  function automatic logic [7:0] m_status();
    return {2'b00, m_fovf, m_uovf, m_ferr, m_perr, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  task automatic m_capture(input logic [7:0] d, input bit pe, input bit fe, input bit ov);
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_fovf = 1;
    m_perr |= pe; m_ferr |= fe; m_uovf |= ov;
  endtask

  task automatic m_clear(input logic [7:0] w);
    if (w[2]) m_perr = 0;
    if (w[3]) m_ferr = 0;
    if (w[4]) m_uovf = 0;
    if (w[5]) m_fovf = 0;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    bus.i_cs = 1; bus.i_we = 1; bus.i_addr = a; bus.i_wdata = d;
    @(negedge clk);
    bus.i_cs = 0; bus.i_we = 0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    bus.i_cs = 1; bus.i_we = 0; bus.i_addr = a;
    @(negedge clk);
    d = bus.o_rdata;
    bus.i_cs = 0;
  endtask

  task automatic chk_status(input string name);
    logic [7:0] v;
    reg_read(A_STATUS, v);
    check(name, 32'(v), 32'(m_status()));
  endtask

  task automatic chk_count(input string name);
    logic [7:0] v;
    reg_read(A_COUNT, v);
    check(name, 32'(v), 32'(mq.size()));
  endtask

  task automatic chk_data(input string name);
    logic [7:0] v, e;
    reg_read(A_DATA, v);
    if (mq.size() != 0) e = mq.pop_front();
    else e = 8'h00;
    check(name, 32'(v), 32'(e));
  endtask

  // Engine model: raise rxrdy until acknowledged, optionally hold it, then drop
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit fe, input bit ov, input int hold);
    int waited, pulses;
    waited = 0; pulses = 0;
    rx_dout = d; perr = pe; ferr = fe; ovf = ov; rxrdy = 1;
    do begin
      @(negedge clk);
      waited++;
    end while (!o_read && waited < 20);
    check("frame_ack", 32'(o_read), 32'd1);
    if (o_read) pulses = 1;
    repeat (hold) begin
      @(negedge clk);
      if (o_read) pulses++;
    end
    rxrdy = 0; perr = 0; ferr = 0; ovf = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_read) pulses++;
    end
    check("frame_pulses", 32'(pulses), 32'd1);
    m_capture(d, pe, fe, ov);
  endtask

  typedef struct {
    logic [7:0]  ctrl;
    logic [18:0] rate;
    logic        eight, pen, ohel;
    int          hi;      // cycles o_rx_rst stays high (12 = never releases within window)
  } vec_t;
  vec_t vt[8];

  initial begin
    logic [7:0] v;
    int n;
    bus.i_cs = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_wdata = 0;

    vt[0] = '{8'hBB, 19'd109,    1'b1, 1'b1, 1'b0, 4};
    vt[1] = '{8'h14, 19'd10417,  1'b1, 1'b0, 1'b0, 12};
    vt[2] = '{8'h00, 19'd333333, 1'b0, 1'b0, 1'b0, 12};
    vt[3] = '{8'h61, 19'd83333,  1'b0, 1'b1, 1'b1, 12};
    vt[4] = '{8'h8C, 19'd109,    1'b0, 1'b0, 1'b0, 4};
    vt[5] = '{8'h0F, 19'd109,    1'b0, 1'b0, 1'b0, 12};
    vt[6] = '{8'hD8, 19'd868,    1'b1, 1'b0, 1'b1, 4};
    vt[7] = '{8'hA7, 19'd1736,   1'b0, 1'b1, 1'b0, 4};

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Reset state
    check("rst_rx_rst", 32'(o_rx_rst), 32'd1);
    check("rst_rate", 32'(o_rate), 32'd10417);
    check("rst_eight", 32'(o_eight), 32'd1);
    check("rst_pen", 32'(o_pen), 32'd0);
    check("rst_ohel", 32'(o_ohel), 32'd0);
    check("rst_rdata", 32'(bus.o_rdata), 32'd0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_read || !o_rx_rst) n++;
    end
    check("rst_idle_engine", 32'(n), 32'd0);
    chk_status("rst_status");
    reg_read(A_CTRL, v);
    check("rst_ctrl", 32'(v), 32'h14);
    chk_count("rst_count");

    // CTRL table: format outputs next cycle and the engine reset window
    for (int i = 0; i < 8; i++) begin
      reg_write(A_CTRL, vt[i].ctrl);
      check($sformatf("tbl%0d_rate", i), 32'(o_rate), 32'(vt[i].rate));
      check($sformatf("tbl%0d_eight", i), 32'(o_eight), 32'(vt[i].eight));
      check($sformatf("tbl%0d_pen", i), 32'(o_pen), 32'(vt[i].pen));
      check($sformatf("tbl%0d_ohel", i), 32'(o_ohel), 32'(vt[i].ohel));
      n = o_rx_rst ? 1 : 0;
      while (o_rx_rst && n < 12) begin
        @(negedge clk);
        if (o_rx_rst) n++;
      end
      check($sformatf("tbl%0d_rst_len", i), 32'(n), 32'(vt[i].hi));
      reg_read(A_CTRL, v);
      check($sformatf("tbl%0d_ctrl_rd", i), 32'(v), 32'(vt[i].ctrl));
    end

    // Random CTRL values against the arithmetic baud model
    for (int i = 0; i < 12; i++) begin
      logic [7:0] c;
      c = 8'($urandom);
      reg_write(A_CTRL, c);
      check("rnd_rate", 32'(o_rate), 32'(m_rate(c[3:0])));
      check("rnd_fmt", {29'd0, o_ohel, o_pen, o_eight}, {29'd0, c[6], c[5], c[4]});
    end

    reg_write(A_CTRL, 8'hBB);
    repeat (6) @(negedge clk);

    // Single frame
    send_frame(8'hA5, 0, 0, 0, 2);
    chk_status("a5_status");
    chk_data("a5_data");
    chk_count("a5_count");

    // Overflow: 9 frames into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, i % 3);
    chk_count("ovf_count");
    chk_status("ovf_status");
    reg_write(A_STATUS, 8'h20); m_clear(8'h20);
    chk_status("ovf_cleared");
    // Pop and push in the same cycle on a full FIFO
    rx_dout = 8'h99; rxrdy = 1;
    bus.i_cs = 1; bus.i_we = 0; bus.i_addr = A_DATA;
    @(negedge clk);
    bus.i_cs = 0;
    v = mq.pop_front();
    check("popush_rdata", 32'(bus.o_rdata), 32'(v));
    check("popush_ack", 32'(o_read), 32'd1);
    rxrdy = 0;
    repeat (3) @(negedge clk);
    m_capture(8'h99, 0, 0, 0);
    chk_count("popush_count");
    chk_status("popush_status");
    for (int i = 0; i < 9; i++) chk_data("drain_data");

    // Parity error flag, clear, and set-wins-over-clear
    send_frame(8'h42, 1, 0, 0, 0);
    chk_status("perr_set");
    reg_write(A_STATUS, 8'h04); m_clear(8'h04);
    chk_status("perr_clear");
    rx_dout = 8'h77; perr = 1; rxrdy = 1;
    bus.i_cs = 1; bus.i_we = 1; bus.i_addr = A_STATUS; bus.i_wdata = 8'h04;
    @(negedge clk);
    bus.i_cs = 0; bus.i_we = 0;
    check("setwin_ack", 32'(o_read), 32'd1);
    rxrdy = 0; perr = 0;
    repeat (3) @(negedge clk);
    m_clear(8'h04); m_capture(8'h77, 1, 0, 0);
    chk_status("setwin_status");
    reg_write(A_STATUS, 8'h3C); m_clear(8'h3C);

    // Randomized traffic against the model
    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                            $urandom_range(0, 7) == 0, $urandom_range(0, 2));
      else if (r < 8) chk_data("rnd_data");
      else if (r == 8) begin
        chk_status("rnd_status");
        chk_count("rnd_count");
      end else begin
        v = 8'($urandom);
        reg_write(A_STATUS, v); m_clear(v);
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) chk_data("rnd_drain");
    reg_write(A_STATUS, 8'h3C); m_clear(8'h3C);

    // Disable during WAIT_CLR: engine reset, no ack, buffer kept
    send_frame(8'h11, 0, 0, 0, 0);
    send_frame(8'h22, 0, 0, 0, 0);
    rx_dout = 8'h5A; rxrdy = 1;
    @(negedge clk);
    check("wc_ack", 32'(o_read), 32'd1);
    m_capture(8'h5A, 0, 0, 0);
    @(negedge clk);
    reg_write(A_CTRL, 8'h3B);
    check("wc_rx_rst", 32'(o_rx_rst), 32'd1);
    n = 0;
    repeat (6) begin
      if (o_read) n++;
      @(negedge clk);
    end
    check("wc_no_read", 32'(n), 32'd0);
    rxrdy = 0;
    chk_count("wc_count");
    for (int i = 0; i < 4; i++) chk_data("wc_data");

    // CTRL write while in ACK forces o_read low
    reg_write(A_CTRL, 8'hBB);
    repeat (6) @(negedge clk);
    rx_dout = 8'h3C; rxrdy = 1;
    @(negedge clk);
    check("ab_ack_seen", 32'(o_read), 32'd1);
    m_capture(8'h3C, 0, 0, 0);
    bus.i_cs = 1; bus.i_we = 1; bus.i_addr = A_CTRL; bus.i_wdata = 8'hBB;
    #1;
    check("ab_read_forced", 32'(o_read), 32'd0);
    @(negedge clk);
    bus.i_cs = 0; bus.i_we = 0; rxrdy = 0;
    check("ab_rx_rst", 32'(o_rx_rst), 32'd1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_read) n++;
    end
    check("ab_no_read", 32'(n), 32'd0);
    chk_count("ab_count");
    chk_data("ab_data");
    chk_data("ab_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that configures, sequences and services the UART_RX engine.
- Drives the engine's reset, baud count and frame-format inputs from a CTRL register.
- Acknowledges each received frame with a one-cycle read pulse and captures the byte into a small FIFO.
- Keeps sticky error flags.
- Presents an 8-bit, 4-register port interface to the processor side.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries; power of 2, minimum 2
RST_CYCLES, 4, cycles o_rx_rst is held high on every engine reset sequence

Ports:
i_clk  in  1  system clock, 100 MHz
i_rst_n  in  1  asynchronous active-low reset
i_cs  in  1  register access strobe
i_we  in  1  1 = write, 0 = read (qualified by i_cs)
i_addr  in  2  0 CTRL, 1 STATUS, 2 DATA, 3 COUNT
i_wdata  in  8  write data
o_rdata  out  8  registered read data, valid the cycle after i_cs
i_rxrdy  in  1  from UART_RX o_rxrdy
i_perr  in  1  from UART_RX o_perr
i_ferr  in  1  from UART_RX o_ferr
i_ovf  in  1  from UART_RX o_ovf
i_rx_dout  in  8  from UART_RX o_rx_dout
o_read  out  1  to UART_RX i_read; one-cycle acknowledge pulse
o_rx_rst  out  1  to UART_RX i_rst; active high
o_eight  out  1  to UART_RX i_eight
o_pen  out  1  to UART_RX i_pen
o_ohel  out  1  to UART_RX i_ohel
o_rate  out  19  to UART_RX i_rate; clocks per bit

Behaviour:
- Reset (async, i_rst_n low):
  - CTRL = 0x14 (sel 4, eight = 1, pen = 0, ohel = 0, en = 0).
  - o_rate = 10417; o_eight = 1; o_pen = 0; o_ohel = 0.
  - o_rx_rst = 1; o_read = 0; o_rdata = 0x00.
  - FIFO empty; all sticky flags 0; FSM = RST_ENG.
- CTRL layout: [3:0] baud sel, [4] eight, [5] pen, [6] ohel, [7] en.
  - o_rate comes from the package table by sel: 0..11 = 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600 baud, giving 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109 clocks.
  - sel 12..15 map to 109.
  - o_rate and the format outputs are registered and update the cycle after a CTRL write.
- STATUS (read): [0] FIFO not empty, [1] FIFO full, [2] perr, [3] ferr, [4] uart ovf, [5] fifo ovf, [7:6] 0.
  - Write-1-to-clear on bits [5:2].
  - A set and a clear on the same cycle: set wins.
- DATA read: pops the FIFO and returns the head entry. On an empty FIFO it returns 0x00 with no side effect. DATA write is ignored.
- COUNT read: returns the FIFO occupancy, zero-extended.
- FSM states:
  - RST_ENG:
    - o_rx_rst = 1; a counter runs for RST_CYCLES cycles.
    - Then go to IDLE if en = 1; otherwise stay, holding o_rx_rst = 1.
  - IDLE: when i_rxrdy = 1, go to ACK. In the same cycle:
    - Push i_rx_dout if the FIFO is not full; otherwise set fifo ovf and drop the byte.
    - OR i_perr, i_ferr and i_ovf into the sticky flags.
  - ACK: o_read = 1 for exactly this cycle, then go to WAIT_CLR.
  - WAIT_CLR: wait for i_rxrdy = 0, then go to IDLE. This guarantees one capture per frame.
- Any CTRL write, or en = 0, from any state: go to RST_ENG next cycle and reload the counter.
  - An ACK in progress is abandoned; o_read is forced to 0.
  - FIFO contents and sticky flags are retained.
- FIFO push and pop in the same cycle:
  - Both occur; count is unchanged.
  - On a full FIFO the push is accepted only when the pop occurs in the same cycle.
- Read and write pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
UART_RX_CTRL_IRQ_EN
- When defined:
  - Adds output o_irq (1 bit, registered).
  - Adds register bit CTRL... (none). Instead, address 3 becomes writable as IRQ_MASK: [0] not empty, [1] full, [2] any error flag. COUNT remains readable at address 3.
  - o_irq = OR of (masked condition); it is 0 at reset and mask resets to 0x00.
- When not defined: no o_irq port; writes to address 3 are ignored.

Decomposition:
- Package uart_rx_ctrl_pkg holds:
  - the 16-entry baud count table (19-bit constants);
  - register address constants;
  - STATUS and CTRL bit-index constants;
  - the FSM state enum (RST_ENG, IDLE, ACK, WAIT_CLR);
  - the CTRL reset value 0x14.
- Sub-module uart_rx_fifo is natural: parameterised depth, 8-bit data, push/pop/full/empty/count, async active-low reset.

Test Plan:
- Release i_rst_n, no access -> o_rx_rst = 1; o_rate = 10417; STATUS reads 0x00; o_read stays 0.
- Write CTRL 0xBB -> next cycle o_rate = 109, o_eight = 1, o_pen = 1, o_ohel = 0; o_rx_rst high exactly 4 cycles, then low.
- Engine model raises i_rxrdy with i_rx_dout = 0xA5 and holds it until o_read -> exactly one o_read pulse; STATUS = 0x01; DATA read returns 0xA5; COUNT = 0 afterwards.
- Send 9 frames 0x01..0x09 with no reads -> COUNT = 8; STATUS = 0x23; reads return 0x01..0x08 in order, then 0x00.
- Frame with i_perr = 1 -> STATUS[2] = 1. Write 0x04 to STATUS -> cleared. A perr frame captured in the same cycle as the clear -> bit stays 1.
- Write CTRL with en = 0 while in WAIT_CLR -> o_rx_rst = 1 the next cycle; no o_read pulse; buffered bytes still readable.
